fm_mem_arbiter_rr: RTL and testbench

//   Multi-client feature-map memory arbiter for the conv/pool datapath. Merges NUM_CLIENTS read ports and
//   NUM_CLIENTS write ports onto one single-port feature-map RAM: one access per cycle.

---
 rtl/fm_mem_arbiter_rr.sv | 105 ++++++++++
 tb/tb_fm_mem_arbiter_rr.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fm_mem_arbiter_rr.sv
// fm_mem_arbiter_rr: round-robin arbiter merging N read and N write clients onto one single-port feature-map RAM
// Optional FM_ARB_BOUNDS_CHECK_EN: out-of-range coordinates suppress the RAM access and pulse err_oob.
module fm_mem_arbiter_rr #(
  parameter int NUM_CLIENTS = 2,
  parameter int COORD_BITS = 8,
  parameter int CHANNELS = 4,
  parameter int BITS_PER_CHANNEL = 9,
  parameter int FM_WIDTH = 32,
  parameter int FM_HEIGHT = 32,
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_LIMIT = 4,
  localparam int FM_W = CHANNELS * BITS_PER_CHANNEL,
  localparam int ADDR_BITS = $clog2(FM_WIDTH * FM_HEIGHT)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_CLIENTS-1:0]              rd_req,
  input  logic [NUM_CLIENTS*2*COORD_BITS-1:0] rd_coord,
  output logic [NUM_CLIENTS-1:0]              rd_ready,
  output logic [NUM_CLIENTS-1:0]              rd_valid,
  output logic [FM_W-1:0]                     rd_data,
  input  logic [NUM_CLIENTS-1:0]              wr_req,
  input  logic [NUM_CLIENTS*2*COORD_BITS-1:0] wr_coord,
  input  logic [NUM_CLIENTS*FM_W-1:0]         wr_data,
  output logic [NUM_CLIENTS-1:0]              wr_ready,
  output logic                                mem_en,
  output logic                                mem_we,
  output logic [ADDR_BITS-1:0]                mem_addr,
  output logic [FM_W-1:0]                     mem_wdata,
  input  logic [FM_W-1:0]                     mem_rdata,
  output logic                                err_oob
);
  localparam int N = NUM_CLIENTS;
  localparam int CW = 2 * COORD_BITS;
  localparam int PW = N > 1 ? $clog2(N) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [PW-1:0] rd_ptr, wr_ptr, rd_sel, wr_sel, rk, wk;
  logic [SW-1:0] starve;
  logic rd_any, wr_any, wr_pick, rd_pick, grant, bad;
  logic [CW-1:0] coord;
  logic [COORD_BITS-1:0] x, y;
  logic [MEM_LATENCY-1:0] pv, pb;
  logic [MEM_LATENCY-1:0][PW-1:0] pid;
  // Scan from the pointer downwards so the nearest requester after the pointer wins.
  always_comb begin
    rd_sel = rd_ptr;
    wr_sel = wr_ptr;
    rk = '0;
    wk = '0;
    for (int j = N - 1; j >= 0; j--) begin
      rk = PW'((int'(rd_ptr) + j) % N);
      wk = PW'((int'(wr_ptr) + j) % N);
      if (rd_req[rk]) rd_sel = rk;
      if (wr_req[wk]) wr_sel = wk;
    end
  end
  assign rd_any = |rd_req;
  assign wr_any = |wr_req;
  assign wr_pick = rst_n && wr_any && (!rd_any || 32'(starve) < STARVE_LIMIT);
  assign rd_pick = rst_n && rd_any && !wr_pick;
  assign grant = rd_pick || wr_pick;
  assign coord = wr_pick ? wr_coord[wr_sel*CW +: CW] : rd_coord[rd_sel*CW +: CW];
  assign {y, x} = coord;
`ifdef FM_ARB_BOUNDS_CHECK_EN
  assign bad = 32'(x) >= FM_WIDTH || 32'(y) >= FM_HEIGHT;
`else
  assign bad = 1'b0;
`endif
  assign err_oob = grant && bad;
  assign mem_en = grant && !bad;
  assign mem_we = wr_pick && !bad;
  assign mem_addr = grant ? ADDR_BITS'(y) * ADDR_BITS'(FM_WIDTH) + ADDR_BITS'(x) : '0;
  assign mem_wdata = wr_pick ? wr_data[wr_sel*FM_W +: FM_W] : '0;
  assign rd_data = pv[MEM_LATENCY-1] && !pb[MEM_LATENCY-1] ? mem_rdata : '0;
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rd_ready[i] = rd_pick && rd_sel == PW'(i);
      wr_ready[i] = wr_pick && wr_sel == PW'(i);
      rd_valid[i] = pv[MEM_LATENCY-1] && pid[MEM_LATENCY-1] == PW'(i);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      starve <= '0;
      pv <= '0;
      pb <= '0;
      pid <= '0;
    end else begin
      if (rd_pick) rd_ptr <= rd_sel == PW'(N - 1) ? '0 : rd_sel + 1'b1;
      if (wr_pick) wr_ptr <= wr_sel == PW'(N - 1) ? '0 : wr_sel + 1'b1;
      if (rd_pick || !rd_any) starve <= '0;
      else if (wr_pick && starve != SW'(STARVE_LIMIT)) starve <= starve + 1'b1;
      pv[0] <= rd_pick;
      pb[0] <= bad;
      pid[0] <= rd_sel;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pb[i] <= pb[i-1];
        pid[i] <= pid[i-1];
      end
    end
  end
endmodule

// File: tb/tb_fm_mem_arbiter_rr.sv
// tb_fm_mem_arbiter_rr: directed checks of grants, round-robin, starvation guard, write path and read return
module tb_fm_mem_arbiter_rr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] rd_req, rd_ready, rd_valid, wr_req, wr_ready;
  logic [31:0] rd_coord, wr_coord;
  logic [35:0] rd_data, mem_wdata, mem_rdata;
  logic [71:0] wr_data;
  logic mem_en, mem_we, err_oob;
  logic [9:0] mem_addr;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fm_mem_arbiter_rr dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_coord(rd_coord), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_coord(wr_coord), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_oob(err_oob)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [71:0] o, input logic [71:0] e);
    checks++;
    if (o !== e) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  initial begin
    rd_req = 2'b11;
    wr_req = 2'b11;
    rd_coord = '0;
    wr_coord = '0;
    wr_data = '0;
    mem_rdata = 36'hF0F0F0F0F;
    #12;
    chk("rst_rd_ready", rd_ready, 2'b00);
    chk("rst_wr_ready", wr_ready, 2'b00);
    chk("rst_rd_valid", rd_valid, 2'b00);
    chk("rst_rd_data", rd_data, 36'h0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 10'd0);
    chk("rst_err_oob", err_oob, 1'b0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("first_wr_grant", wr_ready, 2'b01);
    chk("first_rd_grant", rd_ready, 2'b00);
    rd_req = 2'b00;
    wr_req = 2'b00;
    tick;
    rd_req = 2'b10;
    rd_coord = {8'd2, 8'd3, 16'd0};
    mem_rdata = 36'h123456789;
    #1;
    chk("single_rd_ready", rd_ready, 2'b10);
    chk("single_mem_en", mem_en, 1'b1);
    chk("single_mem_we", mem_we, 1'b0);
    chk("single_mem_addr", mem_addr, 10'd67);
    chk("single_mem_wdata", mem_wdata, 36'h0);
    tick;
    rd_req = 2'b00;
    #1;
    chk("single_rd_valid", rd_valid, 2'b10);
    chk("single_rd_data", rd_data, 36'h123456789);
    rd_req = 2'b11;
    rd_coord = {8'd0, 8'd6, 8'd0, 8'd5};
    for (int c = 0; c < 5; c++) begin
      if (c == 4) rd_req = 2'b00;
      #1;
      chk("rr_ready", rd_ready, (c == 4) ? 2'b00 : ((c % 2 != 0) ? 2'b10 : 2'b01));
      chk("rr_valid", rd_valid, (c % 2 != 0) ? 2'b01 : 2'b10);
      if (c < 4) chk("rr_addr", mem_addr, (c % 2 != 0) ? 10'd6 : 10'd5);
      tick;
    end
    wr_req = 2'b01;
    rd_req = 2'b01;
    wr_coord = {16'd0, 8'd1, 8'd0};
    rd_coord = {16'd0, 8'd0, 8'd5};
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("starve_wr_ready", wr_ready, (c % 5 == 4) ? 2'b00 : 2'b01);
      chk("starve_rd_ready", rd_ready, (c % 5 == 4) ? 2'b01 : 2'b00);
      chk("starve_mem_we", mem_we, (c % 5 == 4) ? 1'b0 : 1'b1);
      chk("starve_rd_valid", rd_valid, (c == 5) ? 2'b01 : 2'b00);
      tick;
    end
    wr_req = 2'b00;
    rd_req = 2'b00;
    tick;
    wr_req = 2'b11;
    wr_coord = {8'd31, 8'd31, 8'd1, 8'd0};
    wr_data = {36'hABCDE1234, 36'h011112222};
    #1;
    chk("wr1_ready", wr_ready, 2'b10);
    chk("wr1_mem_en", mem_en, 1'b1);
    chk("wr1_mem_we", mem_we, 1'b1);
    chk("wr1_mem_addr", mem_addr, 10'd1023);
    chk("wr1_mem_wdata", mem_wdata, 36'hABCDE1234);
    tick;
    #1;
    chk("wr0_ready", wr_ready, 2'b01);
    chk("wr0_mem_addr", mem_addr, 10'd32);
    chk("wr0_mem_wdata", mem_wdata, 36'h011112222);
    tick;
    wr_req = 2'b00;
    rd_req = 2'b01;
    #1;
    chk("rstmid_rd_ready", rd_ready, 2'b01);
    tick;
    rd_req = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("rstmid_rd_valid", rd_valid, 2'b00);
    chk("rstmid_rd_data", rd_data, 36'h0);
    tick;
    tick;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rstmid_after_valid", rd_valid, 2'b00);
      tick;
    end
    rd_req = 2'b01;
    rd_coord = {16'd0, 8'd40, 8'd0};
    #1;
    chk("oob_rd_ready", rd_ready, 2'b01);
`ifdef FM_ARB_BOUNDS_CHECK_EN
    chk("oob_mem_en", mem_en, 1'b0);
    chk("oob_err", err_oob, 1'b1);
    tick;
    rd_req = 2'b00;
    #1;
    chk("oob_rd_valid", rd_valid, 2'b01);
    chk("oob_rd_data", rd_data, 36'h0);
    chk("oob_err_clear", err_oob, 1'b0);
`else
    chk("wrap_mem_en", mem_en, 1'b1);
    chk("wrap_mem_addr", mem_addr, 10'd256);
    chk("wrap_err", err_oob, 1'b0);
    tick;
    rd_req = 2'b00;
    #1;
    chk("wrap_rd_valid", rd_valid, 2'b01);
    chk("wrap_rd_data", rd_data, 36'h123456789);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
